// File: rtl/dma_priority.sv
// Channel priority and bus-request stage of an 8237A-style DMA controller.
// Synchronises DREQ, tracks mask/software requests, runs the HRQ/HLDA handshake and grants one channel.
module dma_priority #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NCH-1:0]             DREQ,
  input  logic                       HLDA,
  output logic                       HRQ,
  output logic [NCH-1:0]             DACK,
  input  logic                       cmd_disable,
  input  logic                       cmd_rot_pri,
  input  logic                       cmd_dreq_low,
  input  logic                       cmd_dack_high,
  input  logic                       mclr,
  input  logic                       mask_wr_single,
  input  logic                       mask_wr_all,
  input  logic [$clog2(NCH)-1:0]     mask_ch,
  input  logic                       mask_bit,
  input  logic [NCH-1:0]             mask_all,
  input  logic                       sreq_wr,
  input  logic [$clog2(NCH)-1:0]     sreq_ch,
  input  logic                       sreq_bit,
  input  logic [NCH-1:0]             autoinit,
  input  logic                       svc_done,
  input  logic                       tc,
  output logic                       svc_start,
  output logic [$clog2(NCH)-1:0]     active_ch,
  output logic [NCH-1:0]             mask_q,
  output logic [NCH-1:0]             req_q
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_SERVICE} state_t;

  state_t         state, state_nxt;
  logic           clr;
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] hw, pending;
  logic [NCH-1:0] mask_r, mask_nxt, sreq_r, sreq_nxt, req_r;
  logic [NCH-1:0] dack_oh, win_oh;
  logic [CW-1:0]  pri_ptr, active_r, win, base, idx;
  logic           found, req_any, grant_evt, done_evt;

  // mclr behaves exactly like RESET, so both feed one clear term.
  assign clr = RESET | mclr;

  // NOTE: every clocked block uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= DREQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw        = sync_q[SYNC_STAGES-1] ^ {NCH{cmd_dreq_low}};
  assign pending   = (hw & ~mask_r) | sreq_r;
  assign req_any   = |pending;
  assign grant_evt = (state == S_REQ) && HLDA && req_any;
  assign done_evt  = (state == S_SERVICE) && HLDA && svc_done;

  // Scan from the highest-priority channel; rotation only moves the starting point.
  // NOTE: every variable gets a default at the top of a combinational block so no latch is inferred.
  always_comb begin
    win    = '0;
    win_oh = '0;
    found  = 1'b0;
    idx    = '0;
    base   = cmd_rot_pri ? pri_ptr : '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(base) + i) % NCH);
      if (!found && pending[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    win_oh[win] = 1'b1;
  end

  // Register writes first, then the terminal-count update overrides its own bit.
  always_comb begin
    mask_nxt = mask_r;
    sreq_nxt = sreq_r;
    if (mask_wr_all)         mask_nxt = mask_all;
    else if (mask_wr_single) mask_nxt[mask_ch] = mask_bit;
    if (sreq_wr)             sreq_nxt[sreq_ch] = sreq_bit;
    if (done_evt && tc) begin
      sreq_nxt[active_r] = 1'b0;
      if (!autoinit[active_r]) mask_nxt[active_r] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_any && !cmd_disable) state_nxt = S_REQ;
      S_REQ:     if (!req_any)                state_nxt = S_IDLE;
                 else if (HLDA)               state_nxt = S_GRANT;
      S_GRANT:   state_nxt = HLDA ? S_SERVICE : S_IDLE;
      S_SERVICE: if (!HLDA || svc_done)       state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all control/status registers are cleared on reset; the mask comes up all ones (every channel masked).
  always_ff @(posedge CLK) begin
    if (clr) begin
      mask_r   <= '1;
      sreq_r   <= '0;
      req_r    <= '0;
      active_r <= '0;
      dack_oh  <= '0;
      pri_ptr  <= '0;
    end else begin
      mask_r <= mask_nxt;
      sreq_r <= sreq_nxt;
      req_r  <= pending;
      if (grant_evt) begin
        active_r <= win;
        dack_oh  <= win_oh;
      end else if (state_nxt == S_IDLE) begin
        dack_oh  <= '0;
      end
      if (done_evt) pri_ptr <= CW'((int'(active_r) + 1) % NCH);
    end
  end

  always_comb begin
    HRQ       = (state != S_IDLE);
    svc_start = (state == S_GRANT);
  end

  assign DACK      = cmd_dack_high ? dack_oh : ~dack_oh;
  assign active_ch = active_r;
  assign mask_q    = mask_r;
  assign req_q     = req_r;

endmodule

// File: doc/dma_priority.md
Name: dma_priority

Overview:
- Channel priority and bus-request stage of the 8237A-style DMA controller.
- Sits between the peripheral request lines (DREQ) and CPU hold handshake (HRQ/HLDA) on one side, and the timing-control stage on the other.
- Synchronises and qualifies DREQ, tracks mask and software-request state, raises HRQ, and resolves a winning channel on HLDA.
- Drives DACK, hands the winner to timing control, then returns to idle on end of service.

Parameters:
- NCH, 4, number of DMA channels (DREQ/DACK width; channel index width is 2).
- SYNC_STAGES, 2, flip-flop stages on each DREQ line.

Ports:
- CLK  input  1  controller clock.
- RESET  input  1  synchronous, active-high reset.
- DREQ  input  NCH  asynchronous channel requests, polarity per cmd_dreq_low.
- HLDA  input  1  CPU hold acknowledge.
- HRQ  output  1  hold request to CPU.
- DACK  output  NCH  channel acknowledge, polarity per cmd_dack_high.
- cmd_disable  input  1  controller disable; no new HRQ.
- cmd_rot_pri  input  1  1 = rotating priority, 0 = fixed priority.
- cmd_dreq_low  input  1  DREQ sense is active-low.
- cmd_dack_high  input  1  DACK sense is active-high.
- mclr  input  1  master clear pulse.
- mask_wr_single  input  1  write one mask bit.
- mask_wr_all  input  1  write all mask bits.
- mask_ch  input  2  channel for the single-mask write.
- mask_bit  input  1  value for the single-mask write.
- mask_all  input  NCH  value for the all-mask write.
- sreq_wr  input  1  write software request bit.
- sreq_ch  input  2  channel for the software-request write.
- sreq_bit  input  1  value for the software-request write.
- autoinit  input  NCH  per-channel autoinitialize mode.
- svc_done  input  1  pulse from timing control: service of the active channel ended.
- tc  input  1  valid with svc_done: terminal count or EOP reached.
- svc_start  output  1  one-cycle pulse: active_ch is valid, service begins.
- active_ch  output  2  granted channel.
- mask_q  output  NCH  current mask register, for status readback.
- req_q  output  NCH  qualified pending requests, for status readback.

Behaviour:
- Reset (and mclr) values:
  - HRQ=0, svc_start=0, active_ch=0.
  - DACK = all inactive: 0 when cmd_dack_high=1, else all ones.
  - mask = all ones; software requests = 0.
  - Rotation pointer = ch0 highest; state = IDLE; synchroniser flops cleared.
  - mclr acts identically to RESET but is a synchronous pulse input.
- Request qualification:
  - hw = synchronised DREQ, XOR-inverted when cmd_dreq_low=1.
  - pending = (hw & ~mask) | sreq. Software requests ignore the mask.
  - req_q = pending, registered.
- Priority:
  - Fixed: ch0 highest, ch3 lowest.
  - Rotating: highest = (last_serviced+1) mod NCH. The pointer updates on svc_done only.
  - cmd_rot_pri changing while not IDLE takes effect at the next arbitration.
- State machine IDLE -> REQ -> GRANT -> SERVICE -> IDLE:
  - IDLE:
    - If pending≠0 and cmd_disable=0: go to REQ and set HRQ=1 in the next cycle.
    - Latency: DREQ edge to HRQ is SYNC_STAGES+1 cycles.
  - REQ:
    - HRQ held at 1.
    - If pending becomes 0 before HLDA: drop HRQ and go to IDLE.
    - On HLDA=1 with pending≠0: arbitrate in that cycle, register active_ch, go to GRANT.
  - GRANT:
    - Assert DACK[active_ch] and pulse svc_start for one cycle, then go to SERVICE.
  - SERVICE:
    - Hold DACK and HRQ. New requests are registered but not arbitrated.
    - On svc_done:
      - Deassert DACK and HRQ next cycle; go to IDLE.
      - Update the rotation pointer.
      - If tc=1: clear sreq[active_ch], and set mask[active_ch] unless autoinit[active_ch]=1.
  - HLDA dropping in GRANT or SERVICE: abort to IDLE. DACK and HRQ go inactive next cycle; no mask/sreq/pointer update.
- Simultaneous events:
  - Register writes in the same cycle as a tc update: the tc update wins on its bit; all other bits take the write.
  - mask_wr_all and mask_wr_single together: mask_wr_all wins.
  - mclr has priority over everything except RESET.
- cmd_disable=1 in REQ: finish the handshake normally; only new HRQ assertion from IDLE is blocked.
- DACK is decoded from a registered one-hot, so it is glitch-free.

Test Plan:
- Reset, then unmask ch2 (mask_wr_single ch=2 bit=0), raise DREQ=0100 -> HRQ=1 three cycles later. HLDA=1 -> active_ch=2, svc_start pulse, DACK=0100 (dack_high=1).
- Fixed priority with DREQ=1010 unmasked -> ch1 granted first. After svc_done, ch3 granted.
- Rotating priority: service ch1, then DREQ=1011 -> ch3 granted (order ch2, ch3, ch0, ch1).
- svc_done with tc=1 on ch0, autoinit=0 -> mask_q bit0 set, HRQ=0 next cycle. Repeat with autoinit[0]=1 -> mask bit0 stays 0.
- All masked, sreq_wr ch=3 bit=1 -> ch3 granted despite mask; sreq cleared on tc.
- DREQ withdrawn in REQ -> HRQ drops, state IDLE. HLDA dropped mid-SERVICE -> DACK inactive next cycle, pointer unchanged. mclr mid-service -> all reset values.
